sd_cmd_ctrl: RTL and testbench

SD CMD-line controller. It serialises a 48-bit SD command frame, then optionally receives and checks a 48-bit response. It sequences an internal `crc7` (x^7+x^3+1) instance: resets it, feeds it the covered bits, then shifts out the CRC or compares against it. It sits between the SD host command logic and the CMD pad.

---
 rtl/sd_cmd_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line controller: sends a 48-bit command frame with CRC7 and optionally
// receives and checks a 48-bit response. One CMD bit per iclk cycle.
module sd_cmd_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        iclk,
   input  logic        irst,
   input  logic        istart,
   input  logic [5:0]  icmd_idx,
   input  logic [31:0] iarg,
   input  logic        iresp_en,
   input  logic        icmd,
   output logic        ocmd,
   output logic        ocmd_oe,
   output logic        obusy,
   output logic        odone,
   output logic [5:0]  oresp_idx,
   output logic [31:0] oresp,
   output logic        ocrc_err,
   output logic        otimeout
);

   localparam int unsigned CntMax = (TIMEOUT + 1 > 48) ? TIMEOUT + 1 : 48;
   localparam int unsigned CntW   = $clog2(CntMax);

   typedef enum logic [3:0] {
      StIdle, StTxData, StTxCrc, StTxEnd, StWaitResp, StRxData, StRxCrc, StRxEnd, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [39:0]       sr_q, sr_d;
   logic [6:0]        crc_q, crc_d;
   logic [6:0]        crc_sr_q, crc_sr_d;
   logic              resp_en_q, resp_en_d;
   logic              cmd_q, cmd_d;
   logic              oe_q, oe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [5:0]        resp_idx_q, resp_idx_d;
   logic [31:0]       resp_q, resp_d;
   logic              crc_err_q, crc_err_d;
   logic              tout_q, tout_d;
   logic [39:0]       head;

   // One step of the x^7+x^3+1 CRC generator.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
      logic fb;
      fb = d ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   assign head = {2'b01, icmd_idx, iarg};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      crc_d      = crc_q;
      crc_sr_d   = crc_sr_q;
      resp_en_d  = resp_en_q;
      cmd_d      = cmd_q;
      oe_d       = oe_q;
      done_d     = 1'b0;
      resp_idx_d = resp_idx_q;
      resp_d     = resp_q;
      crc_err_d  = crc_err_q;
      tout_d     = tout_q;

      unique case (state_q)
         StIdle: begin
            crc_d = 7'h00;
            cmd_d = 1'b1;
            oe_d  = 1'b0;
            if (istart) begin
               // First frame bit goes out on the accepting edge.
               cmd_d      = head[39];
               sr_d       = {head[38:0], 1'b0};
               crc_d      = crc7_step(7'h00, head[39]);
               oe_d       = 1'b1;
               cnt_d      = CntW'(1);
               resp_en_d  = iresp_en;
               crc_err_d  = 1'b0;
               tout_d     = 1'b0;
               resp_d     = '0;
               resp_idx_d = '0;
               state_d    = StTxData;
            end
         end
         StTxData: begin
            if (cnt_q == CntW'(40)) begin
               cmd_d    = crc_q[6];
               crc_sr_d = {crc_q[5:0], 1'b0};
               cnt_d    = CntW'(1);
               state_d  = StTxCrc;
            end else begin
               cmd_d = sr_q[39];
               sr_d  = {sr_q[38:0], 1'b0};
               crc_d = crc7_step(crc_q, sr_q[39]);
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StTxCrc: begin
            if (cnt_q == CntW'(7)) begin
               cmd_d   = 1'b1;
               state_d = StTxEnd;
            end else begin
               cmd_d    = crc_sr_q[6];
               crc_sr_d = {crc_sr_q[5:0], 1'b0};
               cnt_d    = cnt_q + CntW'(1);
            end
         end
         StTxEnd: begin
            oe_d  = 1'b0;
            cmd_d = 1'b1;
            crc_d = 7'h00;
            cnt_d = CntW'(1);
            if (resp_en_q) begin
               state_d = StWaitResp;
            end else begin
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         StWaitResp: begin
            // cnt_q holds the current wait-cycle number, starting at 1.
            if (!icmd) begin
               crc_d   = crc7_step(7'h00, 1'b0);
               cnt_d   = '0;
               state_d = StRxData;
            end else if (cnt_q == CntW'(TIMEOUT)) begin
               tout_d  = 1'b1;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               crc_d = 7'h00;
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRxData: begin
            sr_d  = {sr_q[38:0], icmd};
            crc_d = crc7_step(crc_q, icmd);
            if (cnt_q == CntW'(38)) begin
               crc_sr_d = crc7_step(crc_q, icmd);
               cnt_d    = '0;
               state_d  = StRxCrc;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRxCrc: begin
            if (icmd != crc_sr_q[6]) crc_err_d = 1'b1;
            crc_sr_d = {crc_sr_q[5:0], 1'b0};
            if (cnt_q == CntW'(6)) begin
               state_d = StRxEnd;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRxEnd: begin
            if (!icmd) crc_err_d = 1'b1;
            resp_idx_d = sr_q[37:32];
            resp_d     = sr_q[31:0];
            done_d     = 1'b1;
            state_d    = StDone;
         end
         StDone: begin
            crc_d   = 7'h00;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         sr_q       <= '0;
         crc_q      <= '0;
         crc_sr_q   <= '0;
         resp_en_q  <= 1'b0;
         cmd_q      <= 1'b1;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         resp_idx_q <= '0;
         resp_q     <= '0;
         crc_err_q  <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         crc_q      <= crc_d;
         crc_sr_q   <= crc_sr_d;
         resp_en_q  <= resp_en_d;
         cmd_q      <= cmd_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         resp_idx_q <= resp_idx_d;
         resp_q     <= resp_d;
         crc_err_q  <= crc_err_d;
         tout_q     <= tout_d;
      end
   end

   assign ocmd      = cmd_q;
   assign ocmd_oe   = oe_q;
   assign obusy     = busy_q;
   assign odone     = done_q;
   assign oresp_idx = resp_idx_q;
   assign oresp     = resp_q;
   assign ocrc_err  = crc_err_q;
   assign otimeout  = tout_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Bench for sd_cmd_ctrl: directed SD commands plus randomized commands/responses
// checked against a CRC-by-long-division frame model.
module tb_sd_cmd_ctrl;
   localparam int TO = 20;

   logic        iclk = 1'b0;
   logic        irst = 1'b1;
   logic        istart = 1'b0;
   logic [5:0]  icmd_idx = '0;
   logic [31:0] iarg = '0;
   logic        iresp_en = 1'b0;
   logic        icmd = 1'b1;
   logic        ocmd, ocmd_oe, obusy, odone, ocrc_err, otimeout;
   logic [5:0]  oresp_idx;
   logic [31:0] oresp;

   int checks = 0;
   int failures = 0;

   sd_cmd_ctrl #(.TIMEOUT(TO)) dut (
      .iclk(iclk), .irst(irst), .istart(istart), .icmd_idx(icmd_idx), .iarg(iarg),
      .iresp_en(iresp_en), .icmd(icmd), .ocmd(ocmd), .ocmd_oe(ocmd_oe), .obusy(obusy),
      .odone(odone), .oresp_idx(oresp_idx), .oresp(oresp), .ocrc_err(ocrc_err),
      .otimeout(otimeout)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7_div(input logic [39:0] m);
      logic [46:0] v;
      v = {m, 7'b0};
      for (int i = 46; i >= 7; i--) if (v[i]) v = v ^ (47'h89 << (i - 7));
      return v[6:0];
   endfunction

   function automatic logic [47:0] mk_frame(input logic [39:0] head);
      return {head, crc7_div(head), 1'b1};
   endfunction

   // s = wait cycle in which the response start bit is driven (1-based).
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic resp_en,
                          input int s, input logic [47:0] resp, input bit pulse,
                          output logic [47:0] ser, output logic [5:0] g_idx,
                          output logic [31:0] g_resp, output logic g_err, output logic g_tout);
      int oe_cnt, k, exp_k;
      logic e_err, e_tout;
      logic [5:0] e_idx;
      logic [31:0] e_resp;
      oe_cnt = 0;
      ser = '0;
      icmd = 1'b1; icmd_idx = idx; iarg = arg; iresp_en = resp_en; istart = 1'b1;
      @(posedge iclk);
      for (int i = 0; i < 48; i++) begin
         @(negedge iclk);
         if (i == 0) begin
            istart = 1'b0; icmd_idx = ~idx; iarg = ~arg; iresp_en = ~resp_en;
            check("busy_after_start", obusy, 1);
         end
         if (pulse && i == 5) istart = 1'b1;
         if (i == 6) istart = 1'b0;
         ser = {ser[46:0], ocmd};
         oe_cnt += int'(ocmd_oe);
      end
      check("tx_frame", ser, mk_frame({2'b01, idx, arg}));
      check("oe_cycles", oe_cnt, 48);
      exp_k = !resp_en ? 1 : (s <= TO ? s + 48 : TO + 1);
      k = 1;
      while (k <= 200) begin
         @(negedge iclk);
         if (odone) break;
         icmd = (resp_en && k >= s && k < s + 48) ? resp[47 - (k - s)] : 1'b1;
         k++;
      end
      icmd = 1'b1;
      check("done_cycle", 64'(k), 64'(exp_k));
      check("oe_released", ocmd_oe, 0);
      check("busy_at_done", obusy, 1);
      if (resp_en && s <= TO) begin
         e_idx = resp[45:40]; e_resp = resp[39:8]; e_tout = 1'b0;
         e_err = (crc7_div(resp[47:8]) != resp[7:1]) || !resp[0];
      end else begin
         e_idx = '0; e_resp = '0; e_err = 1'b0; e_tout = resp_en;
      end
      g_idx = oresp_idx; g_resp = oresp; g_err = ocrc_err; g_tout = otimeout;
      check("resp_idx", oresp_idx, e_idx);
      check("resp_arg", oresp, e_resp);
      check("crc_err", ocrc_err, e_err);
      check("timeout", otimeout, e_tout);
      @(negedge iclk);
      check("done_pulse_end", {odone, obusy}, 2'b00);
   endtask

   task automatic check_reset_state(input string tag);
      check(tag, {ocmd, ocmd_oe, obusy, odone, oresp_idx, oresp, ocrc_err, otimeout},
            {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0});
   endtask

   task automatic reset_mid(input bit in_rx);
      int seen;
      icmd_idx = 6'd17; iarg = 32'hDEAD_BEEF; iresp_en = in_rx; istart = 1'b1;
      @(posedge iclk);
      @(negedge iclk);
      istart = 1'b0;
      if (in_rx) begin
         repeat (48) @(negedge iclk);
         icmd = 1'b0;
         repeat (10) begin
            @(negedge iclk);
            icmd = 1'($urandom_range(0, 1));
         end
      end else begin
         repeat (10) @(negedge iclk);
      end
      irst = 1'b1;
      @(posedge iclk);
      @(negedge iclk);
      irst = 1'b0; icmd = 1'b1;
      check_reset_state(in_rx ? "reset_mid_rx" : "reset_mid_tx");
      seen = 0;
      repeat (70) begin
         @(negedge iclk);
         seen += int'(odone) + int'(ocmd_oe);
      end
      check(in_rx ? "no_done_after_rx_rst" : "no_done_after_tx_rst", 64'(seen), 0);
   endtask

   logic [47:0] ser, r;
   logic [39:0] h;
   logic [5:0]  g_idx;
   logic [31:0] g_resp;
   logic        g_err, g_tout;

   initial begin
      repeat (3) @(negedge iclk);
      check_reset_state("reset_values");
      irst = 1'b0;
      @(negedge iclk);

      run_cmd(6'd0, 32'h0, 1'b0, 0, 48'h0, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("cmd0_serial", ser, 48'h400000000095);

      r = 48'h08000001AA13;
      run_cmd(6'd8, 32'h1AA, 1'b1, 6, r, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("cmd8_serial", ser, 48'h48000001AA87);
      check("cmd8_resp", {g_idx, g_resp, g_err, g_tout}, {6'd8, 32'h1AA, 1'b0, 1'b0});

      run_cmd(6'd8, 32'h1AA, 1'b1, 3, r ^ 48'h100, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("flip_arg_err", g_err, 1);
      run_cmd(6'd8, 32'h1AA, 1'b1, 2, r & ~48'h1, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("end_bit0_err", g_err, 1);

      run_cmd(6'd8, 32'h1AA, 1'b1, TO + 5, r, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("timeout_set", g_tout, 1);
      run_cmd(6'd8, 32'h1AA, 1'b1, TO, r, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("last_cycle_start", {g_tout, g_err}, 2'b00);

      run_cmd(6'd8, 32'h1AA, 1'b0, 0, r, 1'b1, ser, g_idx, g_resp, g_err, g_tout);
      check("pulse_ignored", ser, 48'h48000001AA87);
      run_cmd(6'd17, 32'h0, 1'b0, 0, r, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("cmd17_b2b", ser, 48'h510000000055);

      reset_mid(1'b0);
      run_cmd(6'd0, 32'h0, 1'b0, 0, r, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("cmd0_after_tx_rst", ser, 48'h400000000095);
      reset_mid(1'b1);
      run_cmd(6'd0, 32'h0, 1'b0, 0, r, 1'b0, ser, g_idx, g_resp, g_err, g_tout);
      check("cmd0_after_rx_rst", ser, 48'h400000000095);

      for (int n = 0; n < 25; n++) begin
         h = {1'b0, 1'($urandom_range(0, 1)), 6'($urandom), 32'($urandom)};
         r = mk_frame(h);
         case ($urandom_range(0, 3))
            1: r[$urandom_range(1, 45)] ^= 1'b1;
            2: r[0] = 1'b0;
            default: ;
         endcase
         run_cmd(6'($urandom), 32'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, TO + 3)), r, bit'($urandom_range(0, 1)),
                 ser, g_idx, g_resp, g_err, g_tout);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
